// File: rtl/imyfusion_mix.sv
// rtl/imyfusion_mix.sv - dual-channel IR/CCD fusion mixer with per-frame weight crossfade
module imyfusion_mix #(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 10,
  parameter int WEIGHT_W  = 4,
  parameter int RAMP_STEP = 1,
  parameter int RAMP_EN   = 1
) (
  input  logic                pixelclk_is,
  input  logic                reset_is,
  input  logic                vsync_is,
  input  logic                valid_is,
  input  logic [CNT_W-1:0]    ycount_im,
  input  logic [CNT_W-1:0]    xcount_im,
  input  logic [DATA_W-1:0]   ir_data_im,
  input  logic [DATA_W-1:0]   ccd_data_im,
  input  logic [3:0]          mode_im,
  input  logic [WEIGHT_W-1:0] weight_im,
  output logic                vsync_os,
  output logic                valid_os,
  output logic [CNT_W-1:0]    ycount_om,
  output logic [CNT_W-1:0]    xcount_om,
  output logic [DATA_W-1:0]   data_om,
  output logic                ramp_active_os
);

  localparam int PW = DATA_W + WEIGHT_W + 1;
  localparam int SW = PW + 1;
  localparam logic [WEIGHT_W:0]   F_W    = (WEIGHT_W+1)'(1 << WEIGHT_W);
  localparam logic [WEIGHT_W:0]   HALF_W = F_W >> 1;
  localparam logic [WEIGHT_W+1:0] STEP_X = (WEIGHT_W+2)'(RAMP_STEP);

  // frame configuration: latched mode, target weight T, effective weight E
  logic [3:0]        mode_q;
  logic [WEIGHT_W:0] t_q, e_q;

  logic [WEIGHT_W:0]   t_nxt, e_nxt, e_sel, t_sel;
  logic [3:0]          mode_sel;
  logic [WEIGHT_W+1:0] e_x, t_x, e_up, e_dn;

  // stage registers
  logic                s1_vsync, s1_valid, s1_ramp;
  logic [CNT_W-1:0]    s1_y, s1_x;
  logic [DATA_W-1:0]   s1_ir, s1_ccd;
  logic [3:0]          s1_mode;
  logic [WEIGHT_W:0]   s1_e;

  logic                s2_vsync, s2_valid, s2_ramp;
  logic [CNT_W-1:0]    s2_y, s2_x;
  logic [PW-1:0]       s2_p_ir, s2_p_ccd;
  logic [DATA_W-1:0]   s2_max, s2_min;
  logic [3:0]          s2_mode;

  logic [SW-1:0]       sum;
  logic [DATA_W-1:0]   blend, mux_out;

  // next target and ramped effective weight for a frame start this cycle
  always_comb begin
    t_nxt = t_q;
    case (mode_im)
      4'd0:       t_nxt = F_W;
      4'd1:       t_nxt = '0;
      4'd3, 4'd4: t_nxt = t_q;
      default:    t_nxt = {1'b0, weight_im};
    endcase
    e_x  = {1'b0, e_q};
    t_x  = {1'b0, t_nxt};
    e_up = e_x + STEP_X;
    e_dn = e_x - STEP_X;
    e_nxt = e_q;
    if (RAMP_EN == 0) begin
      e_nxt = t_nxt;
    end else if (t_x > e_x) begin
      e_nxt = (e_up > t_x) ? t_nxt : e_up[WEIGHT_W:0];
    end else if (t_x < e_x) begin
      // clamp at T: stepping down would cross or reach it
      e_nxt = (e_x < STEP_X + t_x) ? t_nxt : e_dn[WEIGHT_W:0];
    end
    // the pixel carried with vsync already sees the new configuration
    mode_sel = vsync_is ? mode_im : mode_q;
    e_sel    = vsync_is ? e_nxt   : e_q;
    t_sel    = vsync_is ? t_nxt   : t_q;
  end

  // configuration latch, only updated on frame starts
  always_ff @(posedge pixelclk_is or posedge reset_is) begin
    if (reset_is) begin
      mode_q <= 4'd2;
      t_q    <= HALF_W;
      e_q    <= HALF_W;
    end else if (vsync_is) begin
      mode_q <= mode_im;
      t_q    <= t_nxt;
      e_q    <= e_nxt;
    end
  end

  // stage 1: capture pixel, timing and configuration snapshot
  always_ff @(posedge pixelclk_is or posedge reset_is) begin
    if (reset_is) begin
      s1_vsync <= 1'b0;
      s1_valid <= 1'b0;
      s1_ramp  <= 1'b0;
      s1_y     <= '0;
      s1_x     <= '0;
      s1_ir    <= '0;
      s1_ccd   <= '0;
      s1_mode  <= '0;
      s1_e     <= '0;
    end else begin
      s1_vsync <= vsync_is;
      s1_valid <= valid_is;
      s1_ramp  <= (e_sel != t_sel);
      s1_y     <= ycount_im;
      s1_x     <= xcount_im;
      s1_ir    <= ir_data_im;
      s1_ccd   <= ccd_data_im;
      s1_mode  <= mode_sel;
      s1_e     <= e_sel;
    end
  end

  // stage 2: weighted products and max/min selection
  always_ff @(posedge pixelclk_is or posedge reset_is) begin
    if (reset_is) begin
      s2_vsync <= 1'b0;
      s2_valid <= 1'b0;
      s2_ramp  <= 1'b0;
      s2_y     <= '0;
      s2_x     <= '0;
      s2_p_ir  <= '0;
      s2_p_ccd <= '0;
      s2_max   <= '0;
      s2_min   <= '0;
      s2_mode  <= '0;
    end else begin
      s2_vsync <= s1_vsync;
      s2_valid <= s1_valid;
      s2_ramp  <= s1_ramp;
      s2_y     <= s1_y;
      s2_x     <= s1_x;
      s2_p_ir  <= PW'(s1_ir) * PW'(s1_e);
      s2_p_ccd <= PW'(s1_ccd) * PW'(F_W - s1_e);
      s2_max   <= (s1_ir >= s1_ccd) ? s1_ir : s1_ccd;
      s2_min   <= (s1_ir >= s1_ccd) ? s1_ccd : s1_ir;
      s2_mode  <= s1_mode;
    end
  end

  // rounded blend and mode mux; the blend cannot exceed full scale
  always_comb begin
    sum   = SW'(s2_p_ir) + SW'(s2_p_ccd) + SW'(HALF_W);
    blend = DATA_W'(sum >> WEIGHT_W);
    case (s2_mode)
      4'd3:    mux_out = s2_max;
      4'd4:    mux_out = s2_min;
      default: mux_out = blend;
    endcase
  end

  // stage 3: output registers with valid gating
  always_ff @(posedge pixelclk_is or posedge reset_is) begin
    if (reset_is) begin
      vsync_os       <= 1'b0;
      valid_os       <= 1'b0;
      ycount_om      <= '0;
      xcount_om      <= '0;
      data_om        <= '0;
      ramp_active_os <= 1'b0;
    end else begin
      vsync_os       <= s2_vsync;
      valid_os       <= s2_valid;
      ycount_om      <= s2_y;
      xcount_om      <= s2_x;
      data_om        <= s2_valid ? mux_out : '0;
      ramp_active_os <= s2_ramp;
    end
  end

endmodule

// File: tb/tb_imyfusion_mix.sv
// tb/tb_imyfusion_mix.sv - self-checking bench for imyfusion_mix (ramped and jump variants)
module tb_imyfusion_mix;

  localparam int F    = 16;
  localparam int STEP = 1;

  logic       clk = 1'b0;
  logic       reset_is = 1'b1;
  logic       vsync_is = 1'b0, valid_is = 1'b0;
  logic [9:0] ycount_im = '0, xcount_im = '0;
  logic [7:0] ir_data_im = '0, ccd_data_im = '0;
  logic [3:0] mode_im = '0, weight_im = '0;

  logic       r_vsync, r_valid, r_ramp, j_vsync, j_valid, j_ramp;
  logic [9:0] r_y, r_x, j_y, j_x;
  logic [7:0] r_data, j_data;

  always #5 clk = ~clk;

  imyfusion_mix #(.RAMP_EN(1)) u_ramp (
    .pixelclk_is(clk), .reset_is(reset_is), .vsync_is(vsync_is), .valid_is(valid_is),
    .ycount_im(ycount_im), .xcount_im(xcount_im), .ir_data_im(ir_data_im),
    .ccd_data_im(ccd_data_im), .mode_im(mode_im), .weight_im(weight_im),
    .vsync_os(r_vsync), .valid_os(r_valid), .ycount_om(r_y), .xcount_om(r_x),
    .data_om(r_data), .ramp_active_os(r_ramp)
  );

  imyfusion_mix #(.RAMP_EN(0)) u_jump (
    .pixelclk_is(clk), .reset_is(reset_is), .vsync_is(vsync_is), .valid_is(valid_is),
    .ycount_im(ycount_im), .xcount_im(xcount_im), .ir_data_im(ir_data_im),
    .ccd_data_im(ccd_data_im), .mode_im(mode_im), .weight_im(weight_im),
    .vsync_os(j_vsync), .valid_os(j_valid), .ycount_om(j_y), .xcount_om(j_x),
    .data_om(j_data), .ramp_active_os(j_ramp)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int vs, va, y, x, d1, d0, r1;
  } exp_t;
  exp_t q[$];

  // reference model state: latched mode, target, effective weights of both variants
  int m_mode, m_t, m_e1, m_e0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_pix(input int ir, input int ccd, input int mode, input int e);
    if (mode == 3) return (ir > ccd) ? ir : ccd;
    if (mode == 4) return (ir < ccd) ? ir : ccd;
    return (ir * e + ccd * (F - e) + F / 2) / F;
  endfunction

  task automatic model_reset();
    exp_t z;
    m_mode = 2; m_t = F / 2; m_e1 = F / 2; m_e0 = F / 2;
    z = '{0, 0, 0, 0, 0, 0, 0};
    q.delete();
    q.push_back(z);
    q.push_back(z);
  endtask

  task automatic drive(input int vs, input int va, input int ir, input int ccd,
                       input int mode, input int w);
    exp_t e;
    vsync_is = vs[0]; valid_is = va[0];
    ir_data_im = ir[7:0]; ccd_data_im = ccd[7:0];
    mode_im = mode[3:0]; weight_im = w[3:0];
    ycount_im = 10'($urandom); xcount_im = 10'($urandom);
    if (vs != 0) begin
      m_mode = mode;
      if (mode == 0) m_t = F;
      else if (mode == 1) m_t = 0;
      else if (mode != 3 && mode != 4) m_t = w;
      if (m_t > m_e1) m_e1 = (m_e1 + STEP > m_t) ? m_t : m_e1 + STEP;
      else if (m_t < m_e1) m_e1 = (m_e1 - STEP < m_t) ? m_t : m_e1 - STEP;
      m_e0 = m_t;
    end
    e.vs = vs; e.va = va; e.y = int'(ycount_im); e.x = int'(xcount_im);
    e.d1 = (va != 0) ? ref_pix(ir, ccd, m_mode, m_e1) : 0;
    e.d0 = (va != 0) ? ref_pix(ir, ccd, m_mode, m_e0) : 0;
    e.r1 = (m_e1 != m_t) ? 1 : 0;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (q.size() == 3) begin
      e = q.pop_front();
      check("r_vsync", 32'(r_vsync), e.vs);
      check("r_valid", 32'(r_valid), e.va);
      check("r_y", 32'(r_y), e.y);
      check("r_x", 32'(r_x), e.x);
      check("r_data", 32'(r_data), e.d1);
      check("r_ramp", 32'(r_ramp), e.r1);
      check("j_vsync", 32'(j_vsync), e.vs);
      check("j_valid", 32'(j_valid), e.va);
      check("j_y", 32'(j_y), e.y);
      check("j_data", 32'(j_data), e.d0);
      check("j_ramp", 32'(j_ramp), 0);
    end
  endtask

  // one frame: vsync on the first pixel, mode/weight scrambled afterwards; ir<0 => random pixels
  task automatic frame(input int mode, input int w, input int n, input int ir, input int ccd,
                       input int rnd_valid);
    for (int i = 0; i < n; i++) begin
      drive((i == 0) ? 1 : 0,
            (rnd_valid != 0 && i != 0) ? int'($urandom_range(0, 1)) : 1,
            (ir < 0) ? int'($urandom_range(0, 255)) : ir,
            (ir < 0) ? int'($urandom_range(0, 255)) : ccd,
            (i == 0) ? mode : int'($urandom_range(0, 15)),
            (i == 0) ? w : int'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_vsync", 32'(r_vsync), 0);
    check("rst_data", 32'(r_data), 0);
    check("rst_ramp", 32'(r_ramp), 0);
    reset_is = 1'b0;

    // reset configuration: blend with E=8
    repeat (3) drive(0, 1, 200, 100, 5, 0);
    check("reset_blend", 32'(r_data), 150);
    check("reset_noramp", 32'(r_ramp), 0);
    check("reset_novsync", 32'(r_vsync), 0);

    // crossfade toward IR over 8 frames
    frame(0, 0, 3, 200, 100, 0);
    check("ramp_frame1", 32'(r_data), 156);
    check("ramp_frame1_active", 32'(r_ramp), 1);
    check("jump_frame1", 32'(j_data), 200);
    for (int f = 2; f <= 8; f++) frame(0, 0, 3, 200, 100, 0);
    check("ramp_done", 32'(r_ramp), 0);
    frame(0, 0, 3, 200, 100, 0);
    check("ramp_full_ir", 32'(r_data), 200);

    // jump variant reaches CCD-only within the same frame
    frame(1, 0, 3, 200, 100, 0);
    check("jump_ccd", 32'(j_data), 100);
    check("jump_noramp", 32'(j_ramp), 0);

    // max / min modes from the frame's first pixel
    frame(3, 0, 4, 30, 220, 0);
    check("max_mode", 32'(r_data), 220);
    frame(4, 0, 4, 30, 220, 0);
    check("min_mode", 32'(r_data), 30);

    // blend extremes and invalid pixels
    frame(2, 5, 3, 255, 255, 0);
    check("blend_sat", 32'(j_data), 255);
    frame(2, 5, 3, 0, 255, 0);
    check("blend_w5", 32'(j_data), 175);
    repeat (4) drive(0, 0, 123, 45, 0, 0);
    check("invalid_zero", 32'(r_data), 0);

    // randomized frames across all modes, weights and valid patterns
    for (int f = 0; f < 24; f++)
      frame(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(3, 10)), -1, 0, 1);

    // asynchronous reset in the middle of a ramp
    frame(1, 0, 3, 200, 100, 0);
    #2 reset_is = 1'b1;
    #1;
    check("async_rst_data", 32'(r_data), 0);
    check("async_rst_valid", 32'(r_valid), 0);
    check("async_rst_ramp", 32'(r_ramp), 0);
    check("async_rst_x", 32'(j_x), 0);
    @(negedge clk);
    reset_is = 1'b0;
    model_reset();
    frame(0, 0, 3, 200, 100, 0);
    check("ramp_restart", 32'(r_data), 156);
    repeat (3) drive(0, 1, 10, 20, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imyfusion_mix.md
# imyfusion_mix

Parametrised dual-channel fusion mixer: the next-generation replacement for the fixed IR/CCD fusion stage of the imyfusion pipeline. Combines an IR and a CCD luminance stream of configurable width using a per-frame selectable mode. The blend weight crossfades frame by frame toward its target instead of switching abruptly. It sits after the per-channel filtering and before pseudo-colour, and carries pixel timing and coordinates through with fixed, matched latency.

## Interface
- DATA_W, 8, pixel width of both inputs and the output
- CNT_W, 10, width of the x/y coordinate buses
- WEIGHT_W, 4, weight resolution; full scale F = 2^WEIGHT_W
- RAMP_STEP, 1, weight change per frame while ramping (1..F)
- RAMP_EN, 1, 1 = crossfade; 0 = effective weight jumps to target at the frame start

- pixelclk_is  in  1  pixel clock; all logic on the rising edge
- reset_is  in  1  asynchronous, active-high reset
- vsync_is  in  1  one-cycle frame-start pulse
- valid_is  in  1  pixel valid
- ycount_im, xcount_im  in  CNT_W  pixel coordinates
- ir_data_im, ccd_data_im  in  DATA_W  channel pixels
- mode_im  in  4  0 IR only, 1 CCD only, 2 weighted blend, 3 max, 4 min, other values blend
- weight_im  in  WEIGHT_W  IR weight w for mode 2 (CCD weight is F-w)
- vsync_os, valid_os  out  1  delayed vsync_is / valid_is
- ycount_om, xcount_om  out  CNT_W  delayed coordinates
- data_om  out  DATA_W  fused pixel
- ramp_active_os  out  1  high while the effective weight differs from the target

## Operation
- Configuration is sampled only on cycles where vsync_is=1. mode_im and weight_im are ignored at all other times, so mode and weight are constant within a frame.
- At a frame start, the target weight T (WEIGHT_W+1 bits) is set from the sampled mode:
  - mode 0: T = F
  - mode 1: T = 0
  - mode 2 and undefined modes: T = weight_im
  - modes 3 and 4: T is unchanged
- Effective weight E (WEIGHT_W+1 bits) has two states:
  - IDLE (E==T).
  - RAMP (E!=T). At each vsync_is, E moves RAMP_STEP toward the new T, clamped so it never overshoots T.
  - With RAMP_EN=0, E=T immediately at vsync_is.
  - The E update and T latch take effect on the same clock edge. The new E applies to the pixel accompanying vsync_is and to every later pixel.
- Blend datapath, for latched modes 0, 1, 2 and undefined:
  - data = (ir*E + ccd*(F-E) + F/2) >> WEIGHT_W.
  - Product widths are DATA_W+WEIGHT_W+1; the sum is one bit wider.
  - The result is provably ≤ 2^DATA_W - 1, so no saturation logic is required.
- Mode 3 outputs max(ir, ccd); mode 4 outputs min(ir, ccd). Both are exact and do not use E, but E keeps ramping toward the unchanged T.
- data_om is forced to 0 when valid_os=0.
- ramp_active_os = (E != T), registered.
- Reset values:
  - all outputs 0
  - latched mode = 2
  - T = E = F/2
  - all pipeline registers 0

## Timing
- Fixed latency of 3 cycles on every output path. vsync_os, valid_os, ycount_om, xcount_om and data_om stay mutually aligned.
  - Stage 1: input registers plus mode/E snapshot.
  - Stage 2: products and comparison.
  - Stage 3: sum, round, mux, valid gating.
- No back-pressure; one pixel is accepted per clock.
- vsync_is with valid_is=1 on the same cycle: the pixel is processed with the updated configuration.
- Back-to-back vsync_is pulses: each pulse is a frame start, so E steps once per pulse.
- Reset asserted mid-frame: all outputs clear asynchronously, with no partial pixels afterwards. The first frame after release uses the reset configuration until the next vsync_is.
- A mode change to 3 or 4 takes effect with the next frame's first pixel, with no ramp.

## Test plan
- Reset then release, WEIGHT_W=4, no vsync; ir=200, ccd=100, valid=1 → data_om=150 three cycles later; ramp_active_os=0; vsync_os=0.
- vsync with mode 0, RAMP_EN=1, RAMP_STEP=1 (E starts at 8) → E goes 9..16 over 8 frames; ir=200, ccd=100 gives frame-1 output (1800+700+8)>>4=156; ramp_active_os drops after frame 8; then data_om=200.
- RAMP_EN=0, mode 1 at vsync → the same-frame output equals ccd (100); ramp_active_os stays 0.
- Mode 3, then mode 4 with ir=30, ccd=220 → 220, then 30, each from that frame's first pixel; mode_im toggling mid-frame has no effect.
- Mode 2, w=5, extremes ir=255, ccd=255 → 255; ir=0, ccd=255 → (0+2805+8)>>4=175; valid_is=0 pixels → data_om=0 with coordinates still delayed by 3.
- Assert reset_is mid-ramp between clock edges → outputs 0 immediately, E=T=8 after release; a later vsync restarts the ramp from 8.
